alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the datapath's combinational 2-bit ALU. Adds variable-amount shifts, bitwise logic, an unsigned multiply, status flags and a start/done handshake, so multi-cycle operations run on one shared shifter/adder instead of wide combinational logic. Sits between the register file read ports and the write-back mux; the controller pulses `i_start` and waits for `o_done`.

## Interface
- `N`, 16: operand/result width (≥4).
- `SW`, 4: shift-amount width; 2^SW ≥ N required.

- `i_clk`  in  1  clock, rising edge.
- `i_rst`  in  1  asynchronous reset, active-high.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_a`  in  N  operand A.
- `i_b`  in  N  operand B; shifts use `i_b[SW-1:0]` as the amount.
- `i_control`  in  3  opcode, encoded below.
- `q`  out  N  result, low word.
- `q_hi`  out  N  product high word; 0 for all other ops.
- `o_zero`, `o_carry`, `o_ovf`, `o_neg`  out  1 each  flags.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_done`  out  1  one-cycle pulse; results valid.

## Operation
- Opcodes: 000 add, 010 sub, 001 logical shift right, 011 shift left, 100 and, 101 or, 110 xor, 111 unsigned multiply.
- States: IDLE, SHIFT, MUL, DONE.
- IDLE with `i_start`=1: latch `i_a`, `i_b`, `i_control`.
  - Add/sub/logic: result and flags are registered on this edge. Next state DONE.
  - Shift with k=0: result = A, carry = 0. Next state DONE.
  - Shift with k≥N: result = 0, carry = 0. Next state DONE.
  - Shift with 1≤k<N: next state SHIFT, counter = k.
  - Multiply: next state MUL, counter = N, accumulator = 0.
- SHIFT: shift one bit per edge and decrement the counter. Carry = the last bit shifted out. At counter 1→0, go to DONE.
- MUL: shift-add per edge, LSB of B first, giving a 2N-bit product. After N iterations, go to DONE.
- DONE: `o_done`=1 for exactly one cycle, then IDLE.
- `i_start` outside IDLE, including during DONE, is ignored. It is neither queued nor latched.
- `q`, `q_hi` and the flags hold their values from DONE until the next accepted start updates them.
- Arithmetic is modulo 2^N.
- Flags:
  - `o_zero`: `q`==0; for multiply, the whole 2N-bit product ==0.
  - `o_neg`: `q[N-1]`.
  - `o_carry`: add → carry-out; sub → borrow (A<B unsigned); shift → last bit out; multiply → `q_hi`≠0; logic → 0.
  - `o_ovf`: signed overflow for add/sub; 0 otherwise.
- Operand inputs may change after the start edge without effect.

## Timing
- Reset (asynchronous, any state): state IDLE; `q`, `q_hi`, all flags, `o_busy` and `o_done` = 0; counters cleared. A reset mid-operation aborts it and produces no `o_done`.
- Latency is measured from the start edge to the cycle in which `o_done`=1:
  - add/sub/logic, and shifts with k=0 or k≥N: 1 cycle.
  - shift 1≤k<N: k+1 cycles.
  - multiply: N+1 cycles.
- `o_busy` rises the cycle after the start edge and falls with `o_done`.
- Back-to-back: the earliest accepted start is in the cycle after `o_done` (IDLE). Throughput is 1 op per 2 cycles for single-cycle ops.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset mid-op: N=16, multiply started, `i_rst` asserted at iteration 5 → all outputs 0 immediately and no `o_done`. After release, add 3+4 → `q`=7 with `o_done` one cycle after start.
- Add/sub flags: 0x7FFF+0x0001 → `q`=0x8000, ovf=1, neg=1, carry=0. 0x0000−0x0001 → `q`=0xFFFF, carry=1, ovf=0. 0x1234−0x1234 → zero=1.
- Shifts: A=0x8001, left k=1 → `q`=0x0002, carry=1, `o_done` 2 cycles after start. Right k=15 → `q`=0x0001, 16-cycle latency. k=0 → `q`=0x8001, latency 1.
- Multiply: 0xFFFF×0xFFFF → `q_hi`=0xFFFE, `q`=0x0001, carry=1, latency 17. 0×0x1234 → zero=1.
- Handshake: `i_start` held high through a 9-cycle shift (k=8) with new operands → exactly one op is executed, start re-accepted in the IDLE cycle after `o_done`, and the held results are unchanged until then.
- Logic: 0xF0F0 and/or/xor 0x0FF0 → 0x00F0 / 0xFFF0 / 0xFF00, carry=0, ovf=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU that sits between the register file read
// ports and the write-back mux.
//
// The controller pulses i_start in IDLE. Add, sub and logic ops finish on that
// edge. Shifts move one bit per cycle. Multiply runs a shift-add loop over N
// cycles. o_done pulses for one cycle when results are valid. q, q_hi and the
// flags then hold until the next accepted start replaces them.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous reset, active-high
//   i_start    request, sampled only in IDLE
//   i_a, i_b   operands; shifts take the amount from i_b[SW-1:0]
//   i_control  opcode (see op_e)
//   q, q_hi    result low word / product high word (0 unless multiply)
//   o_zero, o_carry, o_ovf, o_neg   status flags
//   o_busy     high whenever the FSM is not in IDLE
//   o_done     one-cycle pulse when results are valid
module alu_seq #(
  parameter int N  = 16,
  parameter int SW = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_control,
  output logic [N-1:0] q,
  output logic [N-1:0] q_hi,
  output logic         o_zero,
  output logic         o_carry,
  output logic         o_ovf,
  output logic         o_neg,
  output logic         o_busy,
  output logic         o_done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SRL = 3'b001,
    OP_SUB = 3'b010,
    OP_SLL = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_e;

  state_e        state;
  op_e           op;       // opcode latched at start
  logic [N-1:0]  opa;      // multiplicand
  logic [N-1:0]  sh;       // shift work register / low half of the product
  logic [N-1:0]  acc;      // high half of the product
  logic [CW-1:0] cnt;      // remaining shift steps or multiply iterations

  op_e           op_in;
  logic [SW-1:0] k;
  logic [N:0]    sum_w, diff_w, mul_sum;
  logic [N-1:0]  quick_q, sh_shifted, acc_next, mul_lo_next;
  logic          quick_c, quick_v, quick, shift_out;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no branch can leave one unassigned and infer a latch.
    op_in   = op_e'(i_control);
    k       = i_b[SW-1:0];
    sum_w   = {1'b0, i_a} + {1'b0, i_b};
    diff_w  = {1'b0, i_a} - {1'b0, i_b};   // bit N is the borrow
    quick_q = '0;
    quick_c = 1'b0;
    quick_v = 1'b0;
    quick   = 1'b1;
    case (op_in)
      OP_ADD: begin
        quick_q = sum_w[N-1:0];
        quick_c = sum_w[N];
        quick_v = (i_a[N-1] == i_b[N-1]) && (sum_w[N-1] != i_a[N-1]);
      end
      OP_SUB: begin
        quick_q = diff_w[N-1:0];
        quick_c = diff_w[N];
        quick_v = (i_a[N-1] != i_b[N-1]) && (diff_w[N-1] != i_a[N-1]);
      end
      OP_AND: quick_q = i_a & i_b;
      OP_OR:  quick_q = i_a | i_b;
      OP_XOR: quick_q = i_a ^ i_b;
      OP_SRL, OP_SLL: begin
        // Only k==0 (pass A) and k>=N (all bits gone) complete immediately.
        quick_q = (k == '0) ? i_a : '0;
        quick   = (k == '0) || (int'(k) >= N);
      end
      default: quick = 1'b0;   // multiply
    endcase

    // One-bit step of the shared shifter.
    if (op == OP_SLL) begin
      sh_shifted = {sh[N-2:0], 1'b0};
      shift_out  = sh[N-1];
    end else begin
      sh_shifted = {1'b0, sh[N-1:1]};
      shift_out  = sh[0];
    end

    // One shift-add multiply iteration: the multiplier sits in sh and drains
    // LSB first while product bits shift in from the top of acc.
    mul_sum     = sh[0] ? ({1'b0, acc} + {1'b0, opa}) : {1'b0, acc};
    acc_next    = mul_sum[N:1];
    mul_lo_next = {mul_sum[0], sh[N-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the working registers are cleared too, so an aborted operation leaves nothing stale behind.
      state   <= IDLE;
      op      <= OP_ADD;
      opa     <= '0;
      sh      <= '0;
      acc     <= '0;
      cnt     <= '0;
      q       <= '0;
      q_hi    <= '0;
      o_zero  <= 1'b0;
      o_carry <= 1'b0;
      o_ovf   <= 1'b0;
      o_neg   <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            op     <= op_in;
            opa    <= i_a;
            o_busy <= 1'b1;
            if (quick) begin
              q       <= quick_q;
              q_hi    <= '0;
              o_zero  <= (quick_q == '0);
              o_carry <= quick_c;
              o_ovf   <= quick_v;
              o_neg   <= quick_q[N-1];
              o_done  <= 1'b1;
              state   <= DONE;
            end else if (op_in == OP_MUL) begin
              sh    <= i_b;
              acc   <= '0;
              cnt   <= CW'(N);
              state <= MUL;
            end else begin
              sh    <= i_a;
              cnt   <= CW'(k);
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          sh  <= sh_shifted;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            q       <= sh_shifted;
            q_hi    <= '0;
            o_zero  <= (sh_shifted == '0);
            o_carry <= shift_out;
            o_ovf   <= 1'b0;
            o_neg   <= sh_shifted[N-1];
            o_done  <= 1'b1;
            state   <= DONE;
          end
        end
        MUL: begin
          acc <= acc_next;
          sh  <= mul_lo_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            q       <= mul_lo_next;
            q_hi    <= acc_next;
            o_zero  <= ({acc_next, mul_lo_next} == '0);
            o_carry <= (acc_next != '0);
            o_ovf   <= 1'b0;
            o_neg   <= mul_lo_next[N-1];
            o_done  <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin   // DONE: start is ignored here
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=16, SW=4): directed vector table, random
// operations against an arithmetic reference model, and hand-written sequences
// for reset mid-operation and the start/done handshake.
module tb_alu_seq;

  localparam int N = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [N-1:0]  i_a, i_b;
  logic [2:0]    i_control;
  logic [N-1:0]  q, q_hi;
  logic          o_zero, o_carry, o_ovf, o_neg, o_busy, o_done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.N(N), .SW(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_a(i_a), .i_b(i_b), .i_control(i_control),
    .q(q), .q_hi(q_hi),
    .o_zero(o_zero), .o_carry(o_carry), .o_ovf(o_ovf), .o_neg(o_neg),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic [N-1:0] q, qhi;
    logic         z, c, v, n;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions, using wide integers.
  function automatic vec_t model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    vec_t   m;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint r;
    int     sa = int'($signed(a));
    int     sb = int'($signed(b));
    int     ss;
    int     k  = int'(b[3:0]);
    m.op = op; m.a = a; m.b = b;
    m.qhi = '0; m.c = 1'b0; m.v = 1'b0; m.lat = 1;
    case (op)
      3'b000: begin
        r = ua + ub; m.q = r[15:0]; m.c = (r > 65535);
        ss = sa + sb; m.v = (ss > 32767) || (ss < -32768);
      end
      3'b010: begin
        r = ua - ub; m.q = r[15:0]; m.c = (ua < ub);
        ss = sa - sb; m.v = (ss > 32767) || (ss < -32768);
      end
      3'b011: begin
        if (k == 0) m.q = a;
        else if (k >= N) m.q = '0;
        else begin
          r = (ua << k) & 64'hFFFF; m.q = r[15:0];
          m.c = ((ua >> (N - k)) & 1) != 0;
          m.lat = k + 1;
        end
      end
      3'b001: begin
        if (k == 0) m.q = a;
        else if (k >= N) m.q = '0;
        else begin
          r = ua >> k; m.q = r[15:0];
          m.c = ((ua >> (k - 1)) & 1) != 0;
          m.lat = k + 1;
        end
      end
      3'b100: m.q = a & b;
      3'b101: m.q = a | b;
      3'b110: m.q = a ^ b;
      default: begin
        r = ua * ub; m.q = r[15:0]; m.qhi = r[31:16];
        m.c = (m.qhi != 0); m.lat = N + 1;
      end
    endcase
    m.z = (op == 3'b111) ? ({m.qhi, m.q} == 32'd0) : (m.q == '0);
    m.n = m.q[N-1];
    return m;
  endfunction

  // Starts one op, scrambles the operand inputs after the start edge, waits
  // (bounded) for o_done and captures the outputs in that cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, output vec_t r);
    @(negedge i_clk);
    i_start = 1'b1; i_control = op; i_a = a; i_b = b;
    @(posedge i_clk);
    r.lat = 1;
    @(negedge i_clk);
    i_start = 1'b0; i_a = N'($urandom); i_b = N'($urandom); i_control = 3'($urandom);
    check({tag, ".busy"}, o_busy, 1);
    while (!o_done && r.lat < 100) begin
      @(posedge i_clk);
      r.lat++;
      @(negedge i_clk);
    end
    r.q = q; r.qhi = q_hi; r.z = o_zero; r.c = o_carry; r.v = o_ovf; r.n = o_neg;
    @(negedge i_clk);
    check({tag, ".done_pulse"}, o_done, 0);
    check({tag, ".busy_fall"}, o_busy, 0);
    check({tag, ".q_hold"}, q, r.q);
  endtask

  task automatic check_res(input string tag, input vec_t r, input vec_t e);
    check({tag, ".q"},     r.q,   e.q);
    check({tag, ".q_hi"},  r.qhi, e.qhi);
    check({tag, ".zero"},  r.z,   e.z);
    check({tag, ".carry"}, r.c,   e.c);
    check({tag, ".ovf"},   r.v,   e.v);
    check({tag, ".neg"},   r.n,   e.n);
    check({tag, ".lat"},   r.lat, e.lat);
  endtask

  vec_t vecs[13];
  vec_t res, exp_v;
  int   dones;

  initial begin
    //          op      a         b         q         qhi    z     c     v     n     lat
    vecs[0]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[1]  = '{3'b010, 16'h0000, 16'h0001, 16'hFFFF, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[2]  = '{3'b010, 16'h1234, 16'h1234, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'b011, 16'h8001, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[4]  = '{3'b001, 16'h8001, 16'h000F, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16};
    vecs[5]  = '{3'b001, 16'h8001, 16'h0000, 16'h8001, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 17};
    vecs[7]  = '{3'b111, 16'h0000, 16'h1234, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 17};
    vecs[8]  = '{3'b100, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'b101, 16'hF0F0, 16'h0FF0, 16'hFFF0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{3'b110, 16'hF0F0, 16'h0FF0, 16'hFF00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[11] = '{3'b001, 16'h8001, 16'h00F3, 16'h1000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    vecs[12] = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1};

    i_rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0; i_control = '0;
    #12;
    check("reset.q", q, 0);
    check("reset.q_hi", q_hi, 0);
    check("reset.flags", {o_zero, o_carry, o_ovf, o_neg}, 0);
    check("reset.busy_done", {o_busy, o_done}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, res);
      check_res($sformatf("vec%0d", i), res, vecs[i]);
    end

    for (int i = 0; i < 150; i++) begin
      logic [2:0]   op;
      logic [N-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = N'($urandom);
      b  = N'($urandom);
      exp_v = model(op, a, b);
      run_op($sformatf("rnd%0d", i), op, a, b, res);
      check_res($sformatf("rnd%0d", i), res, exp_v);
    end

    // Reset in the middle of a multiply: outputs clear at once, no o_done.
    @(negedge i_clk);
    i_start = 1'b1; i_control = 3'b111; i_a = 16'hFFFF; i_b = 16'hFFFF;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("rst_mid.q", q, 0);
    check("rst_mid.q_hi", q_hi, 0);
    check("rst_mid.flags", {o_zero, o_carry, o_ovf, o_neg}, 0);
    check("rst_mid.busy_done", {o_busy, o_done}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    dones = 0;
    repeat (25) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    check("rst_mid.no_done", dones, 0);
    check("rst_mid.idle", o_busy, 0);
    run_op("rst_after", 3'b000, 16'd3, 16'd4, res);
    check("rst_after.q", res.q, 7);
    check("rst_after.lat", res.lat, 1);

    // Start held high through a k=8 shift while operands change.
    @(negedge i_clk);
    i_start = 1'b1; i_control = 3'b001; i_a = 16'hABCD; i_b = 16'h0008;
    @(posedge i_clk);
    res.lat = 1;
    @(negedge i_clk);
    i_control = 3'b000; i_a = 16'h0001; i_b = 16'h0001;
    dones = 0;
    while (!o_done && res.lat < 100) begin
      @(posedge i_clk);
      res.lat++;
      @(negedge i_clk);
    end
    check("hs.lat", res.lat, 9);
    check("hs.q", q, 16'h00AB);
    check("hs.carry", o_carry, 1);
    @(negedge i_clk);
    check("hs.idle_done", o_done, 0);
    check("hs.idle_busy", o_busy, 0);
    check("hs.hold_q", q, 16'h00AB);
    check("hs.hold_carry", o_carry, 1);
    @(negedge i_clk);
    check("hs.reaccept_done", o_done, 1);
    check("hs.reaccept_q", q, 16'h0002);
    i_start = 1'b0;
    @(negedge i_clk);
    check("hs.end_done", o_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
